ahb3lite_sram_arb2: RTL and testbench
=====================================

# ahb3lite_sram_arb2

Two-port AHB3-Lite front end that shares one single-port SRAM macro between two AHB masters. Each port captures its address phase, a round-robin arbiter grants at most one memory operation per cycle, and losing ports are held in their data phase with HREADYOUTx low. Every memory operation is serialized, so the macro never sees a read and a write in the same cycle and no read/write bypass is needed. The block sits between two AHB3-Lite interconnect slave slots and a generic single-port RAM wrapper.

## Interface

Parameters:
- MEM_DEPTH, 256: memory depth in words; MEM_ABITS = $clog2(MEM_DEPTH).
- HADDR_SIZE, 8: AHB address width.
- HDATA_SIZE, 32: AHB and memory data width; BE_SIZE = HDATA_SIZE/8; MEM_ABITS_LSB = $clog2(BE_SIZE).

Ports (x = 0, 1; one set per AHB port):
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSELx  in  1  slave select.
- HADDRx  in  HADDR_SIZE  address.
- HWDATAx  in  HDATA_SIZE  write data (data phase).
- HRDATAx  out  HDATA_SIZE  read data.
- HWRITEx  in  1  1 = write.
- HSIZEx  in  3  transfer size.
- HTRANSx  in  2  transfer type.
- HREADYx  in  1  bus ready.
- HREADYOUTx  out  1  slave ready.
- HRESPx  out  1  always OKAY (0).
- mem_addr_o  out  MEM_ABITS  word address.
- mem_re_o  out  1  read strobe; data returns on mem_dout_i the next cycle.
- mem_we_o  out  1  write strobe.
- mem_be_o  out  BE_SIZE  byte enables.
- mem_din_o  out  HDATA_SIZE  write data.
- mem_dout_i  in  HDATA_SIZE  read data, 1-cycle registered latency.

## Operation

- **Capture.** An access is captured when HSELx & HREADYx & HTRANSx ∈ {NONSEQ, SEQ}. The capture register holds:
  - write flag;
  - word address HADDRx[MEM_ABITS_LSB +: MEM_ABITS];
  - byte enable: the HSIZE lane mask shifted left by HADDRx low bits, same rule as the single-port SRAM (byte 0x1, half 0x3, word 0xF, truncated to BE_SIZE).
- IDLE and BUSY transfers, and HSELx=0, are never captured.
- **Per-port FSM.**
  - IDLE: nothing pending. HREADYOUTx=1.
  - PEND: a request is captured and waiting for a grant.
    - HREADYOUTx=1 only in a cycle where a write is granted; otherwise 0.
    - Write granted → IDLE, or PEND if a new access is captured in the same cycle.
    - Read granted → RDWAIT.
  - RDWAIT: memory read in flight. HREADYOUTx=1 and HRDATAx=mem_dout_i.
    - Next state is PEND if a new access is captured this cycle, else IDLE.
  - IDLE → PEND on capture.
- **Arbiter.** Only ports in PEND request.
  - A single requester is granted.
  - If both request, the port ≠ last_grant wins.
  - last_grant updates on every grant; reset value 1, so port 0 wins the first tie.
- **Memory drive** (combinational from grant):
  - Granted write: mem_we_o=1, mem_addr_o/mem_be_o from capture, mem_din_o=HWDATAx of the granted port.
  - Granted read: mem_re_o=1, mem_addr_o from capture.
  - No grant: mem_re_o=mem_we_o=0. mem_re_o & mem_we_o is never 1.
- HRDATAx is driven from mem_dout_i at all times; it is valid only in RDWAIT.
- HRESPx is tied to 0.

## Timing

- Reset (synchronous): both FSMs to IDLE, last_grant=1, HREADYOUTx=1, no memory strobes in the reset cycle or the cycle after.
- Reset mid-operation discards pending and in-flight requests. The AHB masters are reset with the block.
- Uncontended write: address phase T0, granted T1, HREADYOUT=1 in T1 (zero wait states).
- Uncontended read: address phase T0, mem_re_o in T1 with HREADYOUT=0, data plus HREADYOUT=1 in T2 (one wait state).
- A contended request waits one extra cycle per grant given to the other port. Worst case is one extra cycle, because requests alternate.
- Back-to-back same-address write then read, either port: the write is granted in cycle N and the read no earlier than N+1, so the read returns the new data.
- A port in RDWAIT or IDLE may capture a new access in the same cycle. The new request can be granted in the following cycle, giving full pipelining.

## Test plan

- Port 0 word write HADDR0=0x10, HWDATA0=0xDEADBEEF → T1: mem_we_o=1, mem_addr_o=0x04, mem_be_o=0xF, HREADYOUT0=1. Then a read of 0x10 → mem_re_o the cycle after capture, then HRDATA0=0xDEADBEEF with HREADYOUT0=1.
- Port 1 byte write HSIZE=byte, HADDR1=0x13, data 0xAA000000 → mem_be_o=0x8. A subsequent word read returns 0xAA in byte 3 and the other bytes unchanged.
- Simultaneous reads on both ports, first after reset:
  - T1: grant port 0; HREADYOUT0=0, HREADYOUT1=0.
  - T2: grant port 1; HREADYOUT0=1.
  - T3: HREADYOUT1=1.
  - mem_re_o never overlaps mem_we_o.
- Port 0 write at 0x20 and port 1 read at 0x20 in the same address phase → write granted first (port 0), and port 1 read returns the new value. Repeat with last_grant=0 → read is granted first and returns the old value.
- Continuous SEQ bursts of 8 on both ports → grants strictly alternate, and no transfer waits more than one extra cycle.
- HRESET asserted while port 0 is in PEND → next cycle HREADYOUT0=1, mem_re_o=mem_we_o=0, and the next tie is granted to port 0.

Source files
------------

// File: rtl/ahb3lite_sram_arb2.sv
// ahb3lite_sram_arb2: two AHB3-Lite slave ports sharing one single-port SRAM
// through a round-robin arbiter that issues at most one memory operation per cycle.
module ahb3lite_sram_arb2 #(
    parameter int MEM_DEPTH  = 256,
    parameter int HADDR_SIZE = 8,
    parameter int HDATA_SIZE = 32,
    localparam int MEM_ABITS     = $clog2(MEM_DEPTH),
    localparam int BE_SIZE       = HDATA_SIZE / 8,
    localparam int MEM_ABITS_LSB = $clog2(BE_SIZE)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL0,
    input  logic [HADDR_SIZE-1:0] HADDR0,
    input  logic [HDATA_SIZE-1:0] HWDATA0,
    output logic [HDATA_SIZE-1:0] HRDATA0,
    input  logic                  HWRITE0,
    input  logic [2:0]            HSIZE0,
    input  logic [1:0]            HTRANS0,
    input  logic                  HREADY0,
    output logic                  HREADYOUT0,
    output logic                  HRESP0,
    input  logic                  HSEL1,
    input  logic [HADDR_SIZE-1:0] HADDR1,
    input  logic [HDATA_SIZE-1:0] HWDATA1,
    output logic [HDATA_SIZE-1:0] HRDATA1,
    input  logic                  HWRITE1,
    input  logic [2:0]            HSIZE1,
    input  logic [1:0]            HTRANS1,
    input  logic                  HREADY1,
    output logic                  HREADYOUT1,
    output logic                  HRESP1,
    output logic [MEM_ABITS-1:0]  mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [BE_SIZE-1:0]    mem_be_o,
    output logic [HDATA_SIZE-1:0] mem_din_o,
    input  logic [HDATA_SIZE-1:0] mem_dout_i
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PEND   = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    function automatic logic [BE_SIZE-1:0] be_of(input logic [2:0] sz, input logic [HADDR_SIZE-1:0] a);
        logic [BE_SIZE-1:0] m;
        for (int i = 0; i < BE_SIZE; i++) m[i] = i < (1 << sz);
        return m << a[MEM_ABITS_LSB-1:0];
    endfunction

    logic [HADDR_SIZE-1:0] haddr [2];
    logic [2:0]            hsize [2];
    logic [1:0]            hwrite;
    logic [1:0]            cap, req, gnt, hrdy, take, wr_q;
    logic [1:0]            st [2];
    logic [1:0]            nxt [2];
    logic [MEM_ABITS-1:0]  addr_q [2];
    logic [BE_SIZE-1:0]    be_q [2];
    logic                  last_grant, gsel;

    assign haddr[0] = HADDR0;
    assign haddr[1] = HADDR1;
    assign hsize[0] = HSIZE0;
    assign hsize[1] = HSIZE1;
    assign hwrite   = {HWRITE1, HWRITE0};
    assign cap[0]   = HSEL0 && HREADY0 && (HTRANS0 inside {NONSEQ, SEQ});
    assign cap[1]   = HSEL1 && HREADY1 && (HTRANS1 inside {NONSEQ, SEQ});

    // A tie goes to the port that was not granted last; reset blocks all grants.
    assign req    = {st[1] == PEND, st[0] == PEND};
    assign gnt[0] = !HRESET && req[0] && (!req[1] || last_grant);
    assign gnt[1] = !HRESET && req[1] && (!req[0] || !last_grant);
    assign gsel   = gnt[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hrdy[i] = st[i] != PEND || (gnt[i] && wr_q[i]);
            take[i] = cap[i] && hrdy[i];
            nxt[i]  = st[i] == PEND && !gnt[i]  ? PEND :
                      st[i] == PEND && !wr_q[i] ? RDWAIT :
                      take[i]                   ? PEND : IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st[0]      <= IDLE;
            st[1]      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            st <= nxt;
            if (|gnt) last_grant <= gnt[1];
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (take[i]) begin
                wr_q[i]   <= hwrite[i];
                addr_q[i] <= MEM_ABITS'(haddr[i] >> MEM_ABITS_LSB);
                be_q[i]   <= be_of(hsize[i], haddr[i]);
            end
        end
    end

    assign mem_we_o   = |gnt && wr_q[gsel];
    assign mem_re_o   = |gnt && !wr_q[gsel];
    assign mem_addr_o = addr_q[gsel];
    assign mem_be_o   = be_q[gsel];
    assign mem_din_o  = gsel ? HWDATA1 : HWDATA0;

    assign HREADYOUT0 = hrdy[0];
    assign HREADYOUT1 = hrdy[1];
    assign HRDATA0    = mem_dout_i;
    assign HRDATA1    = mem_dout_i;
    assign HRESP0     = 1'b0;
    assign HRESP1     = 1'b0;
endmodule

// File: tb/tb_ahb3lite_sram_arb2.sv
// tb_ahb3lite_sram_arb2: directed cycle vectors plus reset and burst sequences
// against a behavioural single-port RAM with one-cycle read latency.
module tb_ahb3lite_sram_arb2;
    typedef struct packed {
        logic        s;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  z;
        logic [7:0]  a;
        logic [31:0] d;
    } port_t;

    typedef struct packed {
        port_t       p0;
        port_t       p1;
        logic [1:0]  rdy;
        logic [1:0]  op;
        logic [7:0]  ma;
        logic [3:0]  be;
        logic [31:0] md;
        logic [1:0]  rc;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    localparam port_t NO = '0;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        HSEL0, HSEL1, HWRITE0, HWRITE1, HREADY0, HREADY1;
    logic        HREADYOUT0, HREADYOUT1, HRESP0, HRESP1;
    logic [7:0]  HADDR0, HADDR1;
    logic [31:0] HWDATA0, HWDATA1, HRDATA0, HRDATA1;
    logic [2:0]  HSIZE0, HSIZE1;
    logic [1:0]  HTRANS0, HTRANS1;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_din, mem_dout;
    logic [31:0] ram [256];
    vec_t        vq [$];
    int          total = 0, bad = 0;

    always #5 HCLK = ~HCLK;

    assign HREADY0 = HREADYOUT0;
    assign HREADY1 = HREADYOUT1;

    always @(posedge HCLK) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        if (mem_re) mem_dout <= ram[mem_addr];
    end

    ahb3lite_sram_arb2 dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSEL0(HSEL0), .HADDR0(HADDR0), .HWDATA0(HWDATA0), .HRDATA0(HRDATA0),
        .HWRITE0(HWRITE0), .HSIZE0(HSIZE0), .HTRANS0(HTRANS0), .HREADY0(HREADY0),
        .HREADYOUT0(HREADYOUT0), .HRESP0(HRESP0),
        .HSEL1(HSEL1), .HADDR1(HADDR1), .HWDATA1(HWDATA1), .HRDATA1(HRDATA1),
        .HWRITE1(HWRITE1), .HSIZE1(HSIZE1), .HTRANS1(HTRANS1), .HREADY1(HREADY1),
        .HREADYOUT1(HREADYOUT1), .HRESP1(HRESP1),
        .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic port_t pi(logic s, logic [1:0] t, logic w, logic [2:0] z, logic [7:0] a, logic [31:0] d);
        return '{s: s, t: t, w: w, z: z, a: a, d: d};
    endfunction

    function automatic void add(port_t p0, port_t p1, logic [1:0] rdy, logic [1:0] op,
                                logic [7:0] ma = 0, logic [3:0] be = 0, logic [31:0] md = 0,
                                logic [1:0] rc = 0, logic [31:0] r0 = 0, logic [31:0] r1 = 0);
        vq.push_back('{p0: p0, p1: p1, rdy: rdy, op: op, ma: ma, be: be, md: md, rc: rc, r0: r0, r1: r1});
    endfunction

    task automatic drive(input port_t p0, input port_t p1);
        HSEL0 = p0.s; HTRANS0 = p0.t; HWRITE0 = p0.w; HSIZE0 = p0.z; HADDR0 = p0.a; HWDATA0 = p0.d;
        HSEL1 = p1.s; HTRANS1 = p1.t; HWRITE1 = p1.w; HSIZE1 = p1.z; HADDR1 = p1.a; HWDATA1 = p1.d;
    endtask

    initial begin
        int ia[2], id[2], stall[2], prev, ngr, g;
        logic done;
        drive(NO, NO);
        // rdy = {HREADYOUT1, HREADYOUT0}, op = {mem_we, mem_re}, rc = which HRDATA to check
        add(NO, NO, 2'b11, 2'b00);
        add(pi(1, 2, 1, 2, 8'h10, 0), NO, 2'b11, 2'b00);
        add(pi(1, 2, 0, 2, 8'h10, 32'hDEADBEEF), NO, 2'b11, 2'b10, 8'h04, 4'hF, 32'hDEADBEEF);
        add(NO, NO, 2'b10, 2'b01, 8'h04);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b01, 32'hDEADBEEF);
        add(NO, pi(1, 2, 1, 2, 8'h10, 0), 2'b11, 2'b00);
        add(NO, pi(1, 2, 1, 0, 8'h13, 32'h11223344), 2'b11, 2'b10, 8'h04, 4'hF, 32'h11223344);
        add(NO, pi(1, 2, 0, 2, 8'h10, 32'hAA000000), 2'b11, 2'b10, 8'h04, 4'h8, 32'hAA000000);
        add(NO, NO, 2'b01, 2'b01, 8'h04);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b10, 0, 32'hAA223344);
        add(pi(1, 2, 0, 2, 8'h10, 0), pi(1, 2, 0, 2, 8'h10, 0), 2'b11, 2'b00);
        add(NO, NO, 2'b00, 2'b01, 8'h04);
        add(NO, NO, 2'b01, 2'b01, 8'h04, 0, 0, 2'b01, 32'hAA223344);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b10, 0, 32'hAA223344);
        add(pi(1, 2, 1, 2, 8'h20, 0), pi(1, 2, 0, 2, 8'h20, 0), 2'b11, 2'b00);
        add(pi(0, 0, 0, 0, 0, 32'hCAFEF00D), NO, 2'b01, 2'b10, 8'h08, 4'hF, 32'hCAFEF00D);
        add(NO, NO, 2'b01, 2'b01, 8'h08);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b10, 0, 32'hCAFEF00D);
        add(pi(1, 2, 0, 2, 8'h10, 0), NO, 2'b11, 2'b00);
        add(NO, NO, 2'b10, 2'b01, 8'h04);
        add(pi(1, 2, 1, 2, 8'h20, 0), pi(1, 2, 0, 2, 8'h20, 0), 2'b11, 2'b00, 0, 0, 0, 2'b01, 32'hAA223344);
        add(pi(0, 0, 0, 0, 0, 32'h12345678), NO, 2'b00, 2'b01, 8'h08);
        add(pi(0, 0, 0, 0, 0, 32'h12345678), NO, 2'b11, 2'b10, 8'h08, 4'hF, 32'h12345678, 2'b10, 0, 32'hCAFEF00D);
        add(NO, pi(1, 2, 0, 2, 8'h20, 0), 2'b11, 2'b00);
        add(NO, NO, 2'b01, 2'b01, 8'h08);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b10, 0, 32'h12345678);
        add(pi(1, 1, 1, 2, 8'h30, 0), pi(0, 2, 1, 2, 8'h30, 0), 2'b11, 2'b00);
        add(pi(1, 0, 1, 2, 8'h30, 0), NO, 2'b11, 2'b00);
        add(NO, NO, 2'b11, 2'b00);
        add(pi(1, 2, 1, 1, 8'h22, 0), NO, 2'b11, 2'b00);
        add(pi(1, 2, 0, 2, 8'h20, 32'hBEEF0000), NO, 2'b11, 2'b10, 8'h08, 4'hC, 32'hBEEF0000);
        add(NO, NO, 2'b10, 2'b01, 8'h08);
        add(NO, NO, 2'b11, 2'b00, 0, 0, 0, 2'b01, 32'hBEEF5678);

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        foreach (vq[i]) begin
            @(negedge HCLK);
            drive(vq[i].p0, vq[i].p1);
            #1;
            chk($sformatf("v%0d_rdy", i), 32'({HREADYOUT1, HREADYOUT0}), 32'(vq[i].rdy));
            chk($sformatf("v%0d_op", i), 32'({mem_we, mem_re}), 32'(vq[i].op));
            chk($sformatf("v%0d_resp", i), 32'({HRESP1, HRESP0}), 0);
            if (vq[i].op != 2'b00) chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vq[i].ma));
            if (vq[i].op[1]) begin
                chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(vq[i].be));
                chk($sformatf("v%0d_din", i), mem_din, vq[i].md);
            end
            if (vq[i].rc[0]) chk($sformatf("v%0d_rdata0", i), HRDATA0, vq[i].r0);
            if (vq[i].rc[1]) chk($sformatf("v%0d_rdata1", i), HRDATA1, vq[i].r1);
        end

        // reset while port 0 is pending; the first tie afterwards must go to port 0
        @(negedge HCLK);
        drive(pi(1, 2, 0, 2, 8'h10, 0), NO);
        @(negedge HCLK);
        drive(NO, NO);
        HRESET = 1'b1;
        #1;
        chk("rst_cycle_strobes", 32'({mem_we, mem_re}), 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        drive(pi(1, 2, 0, 2, 8'h10, 0), pi(1, 2, 0, 2, 8'h20, 0));
        #1;
        chk("rst_after_rdy0", 32'(HREADYOUT0), 1);
        chk("rst_after_strobes", 32'({mem_we, mem_re}), 0);
        @(negedge HCLK);
        drive(NO, NO);
        #1;
        chk("rst_tie_re", 32'(mem_re), 1);
        chk("rst_tie_addr", 32'(mem_addr), 32'h04);
        chk("rst_tie_rdy", 32'({HREADYOUT1, HREADYOUT0}), 0);
        @(negedge HCLK);
        #1;
        chk("rst_rd0_rdy", 32'(HREADYOUT0), 1);
        chk("rst_rd0_data", HRDATA0, 32'hAA223344);
        chk("rst_rd1_addr", 32'({mem_re, mem_addr}), 32'h108);
        @(negedge HCLK);
        #1;
        chk("rst_rd1_rdy", 32'(HREADYOUT1), 1);
        chk("rst_rd1_data", HRDATA1, 32'hBEEF5678);

        // two 8-beat write bursts: grants must alternate, no beat stalls more than one cycle
        ia = '{0, 0};
        id = '{-1, -1};
        stall = '{0, 0};
        prev = -1;
        ngr = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge HCLK);
            HSEL0 = 1'b1; HWRITE0 = 1'b1; HSIZE0 = 3'd2;
            HSEL1 = 1'b1; HWRITE1 = 1'b1; HSIZE1 = 3'd2;
            HTRANS0 = ia[0] >= 8 ? 2'b00 : ia[0] == 0 ? 2'b10 : 2'b11;
            HTRANS1 = ia[1] >= 8 ? 2'b00 : ia[1] == 0 ? 2'b10 : 2'b11;
            HADDR0  = 8'h40 + 8'(4 * ia[0]);
            HADDR1  = 8'h80 + 8'(4 * ia[1]);
            HWDATA0 = id[0] >= 0 ? 32'hA0000000 + 32'(id[0]) : 32'h0;
            HWDATA1 = id[1] >= 0 ? 32'hB0000000 + 32'(id[1]) : 32'h0;
            #1;
            chk($sformatf("burst_c%0d_re", c), 32'(mem_re), 0);
            if (mem_we) begin
                g = mem_addr >= 8'h20 ? 1 : 0;
                chk($sformatf("burst_c%0d_din", c), mem_din,
                    g == 1 ? 32'hB0000000 + 32'(mem_addr - 8'h20) : 32'hA0000000 + 32'(mem_addr - 8'h10));
                if (prev >= 0 && ngr < 16) chk($sformatf("burst_c%0d_alt", c), 32'(g), 32'(1 - prev));
                prev = g;
                ngr++;
            end
            for (int p = 0; p < 2; p++) begin
                if (!(p == 0 ? HREADYOUT0 : HREADYOUT1)) begin
                    stall[p]++;
                    chk($sformatf("burst_c%0d_stall%0d", c, p), 32'(stall[p] > 1), 0);
                end else begin
                    stall[p] = 0;
                    id[p] = ia[p] < 8 ? ia[p] : -1;
                    if (ia[p] < 8) ia[p]++;
                end
            end
            done = ia[0] == 8 && ia[1] == 8 && id[0] < 0 && id[1] < 0;
        end
        chk("burst_done", 32'(done), 1);
        chk("burst_grants", 32'(ngr), 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
